chess_board_mem: RTL and testbench

CHESS_BOARD_MEM -- requirements
Module: chess_board_mem

---
 rtl/chess_board_mem_pkg.sv | 51 +++++
 rtl/chess_board_mem_if.sv | 32 +++
 rtl/chess_board_mem_board_ram.sv | 26 ++
 rtl/chess_board_mem.sv | 177 +++++++++++++++++
 tb/tb_chess_board_mem.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/chess_board_mem_pkg.sv
// chess_pkg: shared types and constants for the chess board memory.
//   mode_e   - path-check geometry selector (rook / bishop / queen / reserved)
//   state_e  - controller FSM states
//   ID_*     - piece id constants (colour bit is added separately)
//   init_piece() - initial board layout, one square at a time
package chess_pkg;

  typedef enum logic [1:0] {M_ROOK, M_BISHOP, M_QUEEN, M_RSVD} mode_e;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SRC, S_WALK, S_DST, S_DONE} state_e;

  // Back-rank ids, files a..h; pawns use ids 1..8 by file.
  localparam int ID_ROOK_A   = 13;
  localparam int ID_KNIGHT_B = 9;
  localparam int ID_BISHOP_C = 11;
  localparam int ID_QUEEN    = 15;
  localparam int ID_KING     = 16;
  localparam int ID_BISHOP_F = 12;
  localparam int ID_KNIGHT_G = 10;
  localparam int ID_ROOK_H   = 14;
  localparam int ID_PAWN_A   = 1;

  // Starting piece code for square sq; only an 8x8 board gets a layout.
  function automatic int init_piece(input int files, input int ranks,
                                    input int sq, input int pw);
    int f, r, id, blk;
    id  = 0;
    blk = 1 << (pw - 1);
    if (files != 8 || ranks != 8) return 0;
    f = sq % 8;
    r = sq / 8;
    case (f)
      0: id = ID_ROOK_A;
      1: id = ID_KNIGHT_B;
      2: id = ID_BISHOP_C;
      3: id = ID_QUEEN;
      4: id = ID_KING;
      5: id = ID_BISHOP_F;
      6: id = ID_KNIGHT_G;
      default: id = ID_ROOK_H;
    endcase
    case (r)
      0:       return id;
      1:       return ID_PAWN_A + f;
      6:       return (ID_PAWN_A + f) | blk;
      7:       return id | blk;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/chess_board_mem_if.sv
// Host + path-check bus for chess_board_mem.
//   master: host side (drives en/rw/adress/data_in, req/mode/src/dst)
//   slave : block side (drives data_out, ready, result_valid, legal, blocked)
interface chess_board_mem_if
  import chess_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int PIECE_W = 6
);
  logic               en;
  logic               rw;
  logic [ADDR_W-1:0]  adress;
  logic [PIECE_W-1:0] data_in;
  logic [PIECE_W-1:0] data_out;
  logic               req;
  mode_e              mode;
  logic [ADDR_W-1:0]  src;
  logic [ADDR_W-1:0]  dst;
  logic               ready;
  logic               result_valid;
  logic               legal;
  logic               blocked;

  modport master (
    output en, rw, adress, data_in, req, mode, src, dst,
    input  data_out, ready, result_valid, legal, blocked
  );
  modport slave (
    input  en, rw, adress, data_in, req, mode, src, dst,
    output data_out, ready, result_valid, legal, blocked
  );
endinterface

// File: rtl/chess_board_mem_board_ram.sv
// board_ram: single-port SQ x PIECE_W square store, synchronous read.
//   clk   - clock
//   en    - port enable; we=1 writes wdata, we=0 loads rdata
//   addr  - square index
//   rdata - holds its value when no read is issued
module board_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 6
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end
endmodule

// File: rtl/chess_board_mem.sv
// chess_board_mem: board memory with host access and a sliding-piece
// path checker (rook / bishop / queen).
//   clk   - clock, rising edge
//   reset - asynchronous, active low; restarts the board load sweep
//   bus   - chess_board_mem_if.slave: host read/write and path-check request
// One RAM port is shared: the load sweep owns it in INIT, the host in IDLE,
// and the walker while a request is in flight.
module chess_board_mem
  import chess_pkg::*;
#(
  parameter  int FILES   = 8,
  parameter  int RANKS   = 8,
  parameter  int PIECE_W = 6,
  localparam int SQ      = FILES * RANKS,
  localparam int ADDR_W  = $clog2(SQ)
) (
  input logic               clk,
  input logic               reset,
  chess_board_mem_if.slave  bus
);
  // One spare bit so file/rank differences stay signed without overflow.
  typedef logic signed [ADDR_W:0] crd_t;

  state_e             st, nst;
  logic [ADDR_W-1:0]  idx, lsrc, ldst;
  mode_e              lmode;
  crd_t               cf, cr, stf, str;
  logic               src_pend, src_col, legal_r, blocked_r, rd_pend;
  logic [PIECE_W-1:0] dout_r, ram_q, ram_wdata;
  logic               ram_en, ram_we;
  logic [ADDR_W-1:0]  ram_addr, step_addr;

  // Geometry of the latched request.
  crd_t sf, sr, tf, tr, dfl, drk, adf, adr, nf, nr, sgn_f, sgn_r;
  logic on_line, geom_ok;

  always_comb begin
    sf    = crd_t'(int'(lsrc) % FILES);
    sr    = crd_t'(int'(lsrc) / FILES);
    tf    = crd_t'(int'(ldst) % FILES);
    tr    = crd_t'(int'(ldst) / FILES);
    dfl   = tf - sf;
    drk   = tr - sr;
    adf   = dfl[ADDR_W] ? -dfl : dfl;
    adr   = drk[ADDR_W] ? -drk : drk;
    sgn_f = dfl[ADDR_W] ? crd_t'(-1) : ((dfl != '0) ? crd_t'(1) : '0);
    sgn_r = drk[ADDR_W] ? crd_t'(-1) : ((drk != '0) ? crd_t'(1) : '0);
    case (lmode)
      M_ROOK:   on_line = (dfl == '0) || (drk == '0);
      M_BISHOP: on_line = (adf == adr);
      M_QUEEN:  on_line = (dfl == '0) || (drk == '0) || (adf == adr);
      default:  on_line = 1'b0;
    endcase
    geom_ok = on_line && (lsrc != ldst) && (int'(lsrc) < SQ) && (int'(ldst) < SQ);
    // Walker only ever steps along a verified line toward dst, so the
    // next square never leaves the board.
    nf        = cf + stf;
    nr        = cr + str;
    step_addr = ADDR_W'(int'(nr) * FILES + int'(nf));
  end

  // Next state and RAM port mux.
  always_comb begin
    nst       = st;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = idx;
    ram_wdata = '0;
    case (st)
      S_INIT: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = PIECE_W'(init_piece(FILES, RANKS, int'(idx), PIECE_W));
        if (int'(idx) == SQ - 1) nst = S_IDLE;
      end
      S_IDLE: begin
        if (bus.req) nst = S_SRC;
        else if (bus.en) begin
          ram_en    = 1'b1;
          ram_we    = bus.rw;
          ram_addr  = bus.adress;
          ram_wdata = bus.data_in;
        end
      end
      S_SRC: begin
        if (!geom_ok) nst = S_DONE;
        else begin
          ram_en   = 1'b1;
          ram_addr = lsrc;
          nst      = S_WALK;
        end
      end
      S_WALK: begin
        // ram_q holds src on the first WALK cycle, an intermediate after.
        if (src_pend ? (ram_q == '0) : (ram_q != '0)) nst = S_DONE;
        else begin
          ram_en   = 1'b1;
          ram_addr = step_addr;
          nst      = (step_addr == ldst) ? S_DST : S_WALK;
        end
      end
      S_DST:   nst = S_DONE;
      S_DONE:  nst = S_IDLE;
      default: nst = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= S_INIT;
    else        st <= nst;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      lmode     <= M_ROOK;
      lsrc      <= '0;
      ldst      <= '0;
      cf        <= '0;
      cr        <= '0;
      stf       <= '0;
      str       <= '0;
      src_pend  <= 1'b0;
      src_col   <= 1'b0;
      legal_r   <= 1'b0;
      blocked_r <= 1'b0;
      rd_pend   <= 1'b0;
      dout_r    <= '0;
    end else begin
      rd_pend <= (st == S_IDLE) && !bus.req && bus.en && !bus.rw;
      if (rd_pend) dout_r <= ram_q;
      case (st)
        S_INIT: idx <= idx + ADDR_W'(1);
        S_IDLE: if (bus.req) begin
          lmode <= bus.mode;
          lsrc  <= bus.src;
          ldst  <= bus.dst;
        end
        S_SRC: begin
          cf        <= sf;
          cr        <= sr;
          stf       <= sgn_f;
          str       <= sgn_r;
          src_pend  <= 1'b1;
          legal_r   <= 1'b0;
          blocked_r <= 1'b0;
        end
        S_WALK: begin
          if (src_pend) src_col <= ram_q[PIECE_W-1];
          if (nst == S_DONE) blocked_r <= !src_pend;
          else begin
            cf <= nf;
            cr <= nr;
          end
          src_pend <= 1'b0;
        end
        S_DST: legal_r <= (ram_q == '0) || (ram_q[PIECE_W-1] != src_col);
        default: ;
      endcase
    end
  end

  board_ram #(.DEPTH(SQ), .AW(ADDR_W), .DW(PIECE_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  assign bus.ready        = (st == S_IDLE);
  assign bus.result_valid = (st == S_DONE);
  assign bus.legal        = (st == S_DONE) && legal_r;
  assign bus.blocked      = (st == S_DONE) && blocked_r;
  assign bus.data_out     = dout_r;
endmodule

// File: tb/tb_chess_board_mem.sv
module tb_chess_board_mem;
  import chess_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  chess_board_mem_if #(.ADDR_W(6), .PIECE_W(6)) b ();

  chess_board_mem #(.FILES(8), .RANKS(8), .PIECE_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    b.en = 1'b1; b.rw = 1'b1; b.adress = 6'(a); b.data_in = 6'(d);
    tick();
    b.en = 1'b0;
  endtask

  // Access edge, then data_out is checked after the following edge.
  task automatic rd(input string tag, input int a, input int exp);
    b.en = 1'b1; b.rw = 1'b0; b.adress = 6'(a);
    tick();
    b.en = 1'b0;
    tick();
    chk(tag, 32'(b.data_out), 32'(exp));
  endtask

  // Path check: result_valid must stay low for cycles 1..1+m after the
  // accepting edge and be high in cycle 2+m. Request inputs are scrambled
  // right after acceptance; collide drives a host write on the accepting
  // edge, poke drives a host write to square 24 while the walk runs.
  task automatic mv(input string tag, input mode_e md, input int s, input int d,
                    input int m, input logic el, input logic eb,
                    input logic collide, input logic poke);
    logic early;
    b.req = 1'b1; b.mode = md; b.src = 6'(s); b.dst = 6'(d);
    if (collide) begin
      b.en = 1'b1; b.rw = 1'b1; b.adress = 6'(d); b.data_in = 6'd7;
    end
    tick();
    b.req = 1'b0; b.en = 1'b0; b.mode = M_RSVD; b.src = '0; b.dst = '0;
    if (poke) begin
      b.en = 1'b1; b.rw = 1'b1; b.adress = 6'd24; b.data_in = 6'd9;
    end
    early = 1'b0;
    for (int k = 0; k <= m; k++) begin
      early |= b.result_valid;
      tick();
    end
    b.en = 1'b0;
    chk({tag, ".early"},   32'(early), 32'd0);
    chk({tag, ".rv"},      32'(b.result_valid), 32'd1);
    chk({tag, ".legal"},   32'(b.legal), 32'(el));
    chk({tag, ".blocked"}, 32'(b.blocked), 32'(eb));
    chk({tag, ".busy"},    32'(b.ready), 32'd0);
    tick();
    chk({tag, ".rv_end"},  32'(b.result_valid), 32'd0);
    chk({tag, ".idle"},    32'(b.ready), 32'd1);
  endtask

  initial begin
    logic seen;
    reset = 1'b0;
    b.en = 1'b0; b.rw = 1'b0; b.adress = '0; b.data_in = '0;
    b.req = 1'b0; b.mode = M_ROOK; b.src = '0; b.dst = '0;

    repeat (3) tick();
    chk("rst.ready", 32'(b.ready), 32'd0);
    chk("rst.rv",    32'(b.result_valid), 32'd0);
    chk("rst.dout",  32'(b.data_out), 32'd0);

    // Load sweep takes exactly 64 cycles.
    reset = 1'b1;
    repeat (63) tick();
    chk("init.ready63", 32'(b.ready), 32'd0);
    tick();
    chk("init.ready64", 32'(b.ready), 32'd1);

    rd("rd.a1", 0, 13);
    rd("rd.e2", 12, 5);
    rd("rd.e8", 60, 48);

    mv("rook_a1a3_blk", M_ROOK, 0, 16, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("dout.hold", 32'(b.data_out), 32'd48);

    wr(8, 0);
    mv("rook_a1a3_ok", M_ROOK, 0, 16, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    mv("req_wins", M_ROOK, 0, 16, 3, 1'b1, 1'b0, 1'b1, 1'b0);
    rd("rd.a3_untouched", 16, 0);

    mv("bish_own", M_BISHOP, 2, 11, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    mv("bish_geo", M_BISHOP, 2, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    mv("rsvd_geo", M_RSVD, 0, 16, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    mv("same_sq", M_QUEEN, 3, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    mv("knight_geo", M_QUEEN, 1, 18, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    mv("no_wrap", M_ROOK, 7, 8, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    mv("empty_src", M_ROOK, 16, 24, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    wr(11, 0);
    wr(51, 0);
    mv("queen_cap", M_QUEEN, 3, 59, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    rd("rd.busy_wr_ignored", 24, 0);
    mv("rook_a1a8_blk", M_ROOK, 0, 56, 7, 1'b0, 1'b1, 1'b0, 1'b0);
    rd("rd.e8_again", 60, 48);

    // Reset in the middle of a walk.
    b.req = 1'b1; b.mode = M_ROOK; b.src = 6'd0; b.dst = 6'd56;
    tick();
    b.req = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("midrst.ready", 32'(b.ready), 32'd0);
    chk("midrst.rv",    32'(b.result_valid), 32'd0);
    chk("midrst.dout",  32'(b.data_out), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 63; k++) begin
      seen |= b.result_valid;
      tick();
    end
    chk("midrst.no_result", 32'(seen), 32'd0);
    chk("midrst.ready63",   32'(b.ready), 32'd0);
    tick();
    chk("midrst.ready64",   32'(b.ready), 32'd1);
    rd("restore.a2", 8, 1);
    rd("restore.d2", 11, 4);
    rd("restore.d7", 51, 36);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
